wb_write_sequencer: RTL and testbench

- Writer end of the register file's single write port (WB_EN / destWB / valueWB).
- Registers the MEM-stage result and drives exactly one register-file write per cycle.
- Serializes instructions that need two register writes (load with base writeback, e.g. LDR post/pre-index with W) into two consecutive write cycles, stalling the pipeline for one cycle.
- Keeps a retired-write counter for debug.

---
 rtl/wb_write_sequencer_if.sv | 37 +++
 rtl/wb_write_sequencer.sv | 95 +++++++++
 tb/tb_wb_write_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/wb_write_sequencer_if.sv
// Bus between the MEM stage and the write-back sequencer.
//   MEM_*    : instruction presented by the MEM stage (master -> slave)
//   WB_EN, destWB, valueWB : register-file write port (slave -> master)
//   stall    : upstream hold request (slave -> master)
//   wr_count : retired-write debug counter (slave -> master)
interface wb_write_sequencer_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
);
  logic                      MEM_valid;
  logic                      MEM_WB_EN;
  logic                      MEM_R_EN;
  logic [REG_ADDR_WIDTH-1:0] MEM_dest;
  logic [DATA_WIDTH-1:0]     MEM_ALU_res;
  logic [DATA_WIDTH-1:0]     MEM_data;
  logic                      MEM_WB2_EN;
  logic [REG_ADDR_WIDTH-1:0] MEM_dest2;
  logic [DATA_WIDTH-1:0]     MEM_value2;
  logic                      WB_EN;
  logic [REG_ADDR_WIDTH-1:0] destWB;
  logic [DATA_WIDTH-1:0]     valueWB;
  logic                      stall;
  logic [CNT_WIDTH-1:0]      wr_count;

  modport master (
    output MEM_valid, MEM_WB_EN, MEM_R_EN, MEM_dest, MEM_ALU_res, MEM_data,
           MEM_WB2_EN, MEM_dest2, MEM_value2,
    input  WB_EN, destWB, valueWB, stall, wr_count
  );

  modport slave (
    input  MEM_valid, MEM_WB_EN, MEM_R_EN, MEM_dest, MEM_ALU_res, MEM_data,
           MEM_WB2_EN, MEM_dest2, MEM_value2,
    output WB_EN, destWB, valueWB, stall, wr_count
  );
endinterface

// File: rtl/wb_write_sequencer.sv
// Write-back sequencer: registers the MEM-stage result and drives the
// register file's single write port, one write per cycle. Loads with base
// writeback need two writes; those are split over two cycles with a
// one-cycle upstream stall.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : wb_write_sequencer_if.slave (MEM_* in; WB_EN/destWB/valueWB,
//          stall, wr_count out)
module wb_write_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_write_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_e;

  state_e                    state_q;
  logic                      pend_q;
  logic                      wb_en_q;
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  logic [DATA_WIDTH-1:0]     value_q;
  logic [REG_ADDR_WIDTH-1:0] dest2_q;
  logic [DATA_WIDTH-1:0]     value2_q;
  logic [CNT_WIDTH-1:0]      cnt_q;

  logic                      stall;
  logic                      accept;
  logic                      split_d;
  logic [DATA_WIDTH-1:0]     prim_val_d;

  // stall depends on registered state only, so upstream never sees a
  // combinational path from MEM_* back to stall.
  assign stall      = (state_q == FIRST) && pend_q;
  assign accept     = bus.MEM_valid && !stall;
  assign prim_val_d = bus.MEM_R_EN ? bus.MEM_data : bus.MEM_ALU_res;
  // Same destination on both writes: the load result wins, base update dropped.
  assign split_d    = bus.MEM_WB_EN && bus.MEM_WB2_EN &&
                      (bus.MEM_dest != bus.MEM_dest2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      wb_en_q  <= 1'b0;
      dest_q   <= '0;
      value_q  <= '0;
      dest2_q  <= '0;
      value2_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_WIDTH'(wb_en_q);
      if (accept) begin
        state_q  <= FIRST;
        pend_q   <= split_d;
        dest2_q  <= bus.MEM_dest2;
        value2_q <= bus.MEM_value2;
        if (bus.MEM_WB_EN) begin
          wb_en_q <= 1'b1;
          dest_q  <= bus.MEM_dest;
          value_q <= prim_val_d;
        end else if (bus.MEM_WB2_EN) begin
          // Lone base update takes the first slot directly.
          wb_en_q <= 1'b1;
          dest_q  <= bus.MEM_dest2;
          value_q <= bus.MEM_value2;
        end else begin
          wb_en_q <= 1'b0;
        end
      end else if (stall) begin
        // Second half of a split instruction; MEM_* is ignored this edge.
        state_q <= SECOND;
        pend_q  <= 1'b0;
        wb_en_q <= 1'b1;
        dest_q  <= dest2_q;
        value_q <= value2_q;
      end else begin
        state_q <= IDLE;
        pend_q  <= 1'b0;
        wb_en_q <= 1'b0;
      end
    end
  end

  assign bus.WB_EN    = wb_en_q;
  assign bus.destWB   = dest_q;
  assign bus.valueWB  = value_q;
  assign bus.stall    = stall;
  assign bus.wr_count = cnt_q;

endmodule

// File: tb/tb_wb_write_sequencer.sv
module tb_wb_write_sequencer;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  wb_write_sequencer_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  wb_write_sequencer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of pending register writes -----
  // Each accepted instruction expands into 0, 1 or 2 writes; one write is
  // retired per cycle, and upstream is stalled while writes are still queued.
  logic [AW+DW-1:0] wq[$];
  bit               m_wb;
  logic [AW-1:0]    m_dest;
  logic [DW-1:0]    m_val;
  bit               m_stall;
  logic [CW-1:0]    m_cnt;

  always @(posedge clk or negedge rst) begin
    logic [DW-1:0]    pv;
    logic [AW+DW-1:0] e;
    if (!rst) begin
      wq.delete();
      m_wb = 0; m_dest = '0; m_val = '0; m_stall = 0; m_cnt = '0;
    end else begin
      if (m_wb) m_cnt = m_cnt + 1'b1;
      if (wq.size() == 0 && bus.MEM_valid) begin
        pv = bus.MEM_R_EN ? bus.MEM_data : bus.MEM_ALU_res;
        if (bus.MEM_WB_EN) wq.push_back({bus.MEM_dest, pv});
        if (bus.MEM_WB2_EN && !(bus.MEM_WB_EN && bus.MEM_dest == bus.MEM_dest2))
          wq.push_back({bus.MEM_dest2, bus.MEM_value2});
      end
      if (wq.size() > 0) begin
        e = wq.pop_front();
        m_wb = 1; m_dest = e[AW+DW-1:DW]; m_val = e[DW-1:0];
      end else begin
        m_wb = 0;
      end
      m_stall = (wq.size() > 0);
    end
  end

  // ---------------- every-cycle comparison against the model -------------
  always @(negedge clk) begin
    chk("cyc_WB_EN", 64'(bus.WB_EN), 64'(m_wb));
    chk("cyc_stall", 64'(bus.stall), 64'(m_stall));
    chk("cyc_wr_count", 64'(bus.wr_count), 64'(m_cnt));
    if (m_wb && bus.WB_EN) begin
      chk("cyc_destWB", 64'(bus.destWB), 64'(m_dest));
      chk("cyc_valueWB", 64'(bus.valueWB), 64'(m_val));
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic drive(input bit v, input bit wb, input bit ren, input int d,
                       input logic [DW-1:0] alu, input logic [DW-1:0] dat,
                       input bit wb2, input int d2, input logic [DW-1:0] v2);
    bus.MEM_valid   = v;
    bus.MEM_WB_EN   = wb;
    bus.MEM_R_EN    = ren;
    bus.MEM_dest    = AW'(d);
    bus.MEM_ALU_res = alu;
    bus.MEM_data    = dat;
    bus.MEM_WB2_EN  = wb2;
    bus.MEM_dest2   = AW'(d2);
    bus.MEM_value2  = v2;
  endtask

  task automatic drive_rand(input bit v);
    drive(v, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)), $urandom, $urandom,
          1'($urandom), int'($urandom_range(0, 15)), $urandom);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic expect_wr(input string n, input int d, input logic [DW-1:0] v, input bit st);
    chk({n, "_WB_EN"}, 64'(bus.WB_EN), 64'(1));
    chk({n, "_destWB"}, 64'(bus.destWB), 64'(d));
    chk({n, "_valueWB"}, 64'(bus.valueWB), 64'(v));
    chk({n, "_stall"}, 64'(bus.stall), 64'(st));
  endtask

  initial begin
    // Reset held with random MEM traffic.
    drive_rand(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_WB_EN", 64'(bus.WB_EN), 64'(0));
      chk("rst_stall", 64'(bus.stall), 64'(0));
      chk("rst_wr_count", 64'(bus.wr_count), 64'(0));
      drive_rand(1);
    end
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_WB_EN", 64'(bus.WB_EN), 64'(0));

    // ALU write r1 = 0x2.
    drive(1, 1, 0, 1, 32'h2, 32'hDEAD, 0, 7, 32'h77);
    @(negedge clk);
    expect_wr("alu", 1, 32'h2, 0);
    idle();
    @(negedge clk);
    chk("alu_wr_count", 64'(bus.wr_count), 64'(1));
    chk("alu_done_WB_EN", 64'(bus.WB_EN), 64'(0));

    // Load with base writeback: r2 = 0x4 then r3 = 0x104.
    drive(1, 1, 1, 2, 32'h55, 32'h4, 1, 3, 32'h104);
    @(negedge clk);
    expect_wr("ldw1", 2, 32'h4, 1);
    drive_rand(1);               // must be ignored while stalled
    @(negedge clk);
    expect_wr("ldw2", 3, 32'h104, 0);
    idle();
    @(negedge clk);
    chk("ldw_wr_count", 64'(bus.wr_count), 64'(3));

    // Same destination on both: only r5 = 0xA.
    drive(1, 1, 1, 5, 32'h99, 32'hA, 1, 5, 32'hB);
    @(negedge clk);
    expect_wr("same", 5, 32'hA, 0);
    idle();
    @(negedge clk);
    chk("same_WB_EN", 64'(bus.WB_EN), 64'(0));
    chk("same_wr_count", 64'(bus.wr_count), 64'(4));

    // Streaming r0..r3, no bubbles.
    drive(1, 1, 0, 0, 32'h10, '0, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      expect_wr("stream", i, 32'h10 + 32'(i), 0);
      if (i < 3) drive(1, 1, 0, i + 1, 32'h11 + 32'(i), '0, 0, 0, '0);
      else idle();
    end
    @(negedge clk);
    chk("stream_end_WB_EN", 64'(bus.WB_EN), 64'(0));
    chk("stream_wr_count", 64'(bus.wr_count), 64'(8));

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      drive_rand($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) bus.MEM_dest2 = bus.MEM_dest;
      @(negedge clk);
    end
    idle();
    repeat (3) @(negedge clk);

    // Reset during the first cycle of a two-write instruction.
    drive(1, 1, 1, 6, '0, 32'h66, 1, 9, 32'h99);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    #1;
    chk("async_WB_EN", 64'(bus.WB_EN), 64'(0));
    chk("async_destWB", 64'(bus.destWB), 64'(0));
    chk("async_valueWB", 64'(bus.valueWB), 64'(0));
    chk("async_stall", 64'(bus.stall), 64'(0));
    chk("async_wr_count", 64'(bus.wr_count), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_WB_EN", 64'(bus.WB_EN), 64'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
